// File: rtl/uart_pkg.sv
// Shared types and constants for the 8N1 UART receiver.
package uart_pkg;

  // Receiver FSM states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  // Depth of the received-byte FIFO.
  localparam int RX_FIFO_DEPTH = 4;

  // Width of one received character.
  localparam int RX_DATA_W = 8;

  // Clocks per bit: truncated quotient of clock rate over baud rate.
  // The receiver relies on this being at least 8.
  function automatic int uart_div(input int clk_freq, input int uart_baud_rate);
    return clk_freq / uart_baud_rate;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Four-entry byte FIFO for the UART receiver. Head byte and non-empty flag
// are registered. A push and a pop on a full FIFO in the same cycle both
// succeed. A push that finds no room is reported on 'drop'.
module uart_rx_fifo
  import uart_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic [RX_DATA_W-1:0] push_data,
  input  logic                 pop,
  output logic [RX_DATA_W-1:0] head,
  output logic                 valid,
  output logic                 drop
);

  localparam int PTR_W = $clog2(RX_FIFO_DEPTH);
  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(RX_FIFO_DEPTH);
  localparam logic [PTR_W:0] ONE_CNT   = (PTR_W + 1)'(1);

  logic [RX_DATA_W-1:0] mem [RX_FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [PTR_W-1:0]     rd_ptr_inc;
  logic [PTR_W:0]       count;
  logic [PTR_W:0]       count_next;
  logic                 full;
  logic                 pop_ok;
  logic                 push_ok;
  logic [RX_DATA_W-1:0] head_next;

  assign full       = (count == DEPTH_CNT);
  assign pop_ok     = pop && (count != '0);
  // The pop frees the slot first, so a full FIFO still accepts a push
  // when a pop happens in the same cycle.
  assign push_ok    = push && (!full || pop_ok);
  assign drop       = push && !push_ok;
  assign rd_ptr_inc = rd_ptr + 1'b1;

  // Next occupancy from the accepted push/pop pair.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    count_next = count;
    case ({push_ok, pop_ok})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  // Next head byte: changes only on a pop or on a push into an empty FIFO.
  always_comb begin
    head_next = head;
    if (pop_ok) begin
      if (count > ONE_CNT) begin
        head_next = mem[rd_ptr_inc];
      end else if (push_ok) begin
        head_next = push_data;
      end
    end else if (push_ok && (count == '0)) begin
      head_next = push_data;
    end
  end

  // Storage array, written at the write pointer on an accepted push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the storage is cleared on reset so the head register never
      // exposes undefined contents; this costs a reset net on every bit,
      // so only reset a memory when that visibility is actually required.
      for (int i = 0; i < RX_FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers, occupancy and the registered head/valid outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head   <= '0;
      valid  <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr_inc;
      end
      count <= count_next;
      head  <= head_next;
      valid <= (count_next != '0);
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop line synchronizer, falling-edge start detect,
// mid-bit sampling at DIV clocks per bit, framing-error pulse, sticky
// overrun flag and a four-entry ready/valid byte FIFO.
module uart_rx
  import uart_pkg::*;
#(
  parameter int clk_freq       = 100000000,
  parameter int uart_baud_rate = 1152000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 uart_rxd,
  output logic [RX_DATA_W-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun,
  input  logic                 overrun_clr,
  output logic                 busy
);

  localparam int DIV   = uart_div(clk_freq, uart_baud_rate);
  localparam int CNT_W = $clog2(DIV);

  // Full bit period and half bit period reload values for the bit timer.
  localparam logic [CNT_W-1:0] CNT_BIT  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(DIV / 2 - 1);

  logic                 rxd_meta;
  logic                 rxd_sync;
  logic                 rxd_prev;
  logic                 start_edge;

  rx_state_t            state;
  logic [CNT_W-1:0]     cnt;
  logic [2:0]           idx;
  logic [RX_DATA_W-1:0] shreg;
  logic                 bit_tick;

  logic                 push;
  logic                 pop;
  logic                 fifo_drop;

  // Bring the asynchronous line into the clock domain; keep the previous
  // synchronized value for falling-edge detection. Idle level is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxd_meta <= 1'b1;
      rxd_sync <= 1'b1;
      rxd_prev <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make each flop load the value its
      // predecessor held before the edge; blocking ones would collapse the
      // chain into a single flop.
      rxd_meta <= uart_rxd;
      rxd_sync <= rxd_meta;
      rxd_prev <= rxd_sync;
    end
  end

  assign start_edge = rxd_prev && !rxd_sync;
  assign bit_tick   = (cnt == '0);

  // Good stop bit sampled: hand the assembled byte to the FIFO this edge,
  // so it shows up on rx_valid one clock after the sample.
  assign push = (state == STOP) && bit_tick && rxd_sync;
  assign pop  = rx_valid && rx_ready;
  assign busy = (state != IDLE);

  // Receiver FSM: start validation, LSB-first data shift, stop check.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      shreg     <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (start_edge) begin
            state <= START;
            cnt   <= CNT_HALF;
          end
        end

        START: begin
          if (bit_tick) begin
            if (!rxd_sync) begin
              state <= DATA;
              cnt   <= CNT_BIT;
              idx   <= '0;
            end else begin
              // Line is high again at mid-start: a glitch, not a frame.
              state <= IDLE;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        DATA: begin
          if (bit_tick) begin
            shreg <= {rxd_sync, shreg[RX_DATA_W-1:1]};
            cnt   <= CNT_BIT;
            if (idx == 3'd7) begin
              state <= STOP;
            end else begin
              idx <= idx + 1'b1;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        STOP: begin
          if (bit_tick) begin
            // Back to IDLE right at mid-stop so a new start edge is caught
            // without requiring any extra idle time.
            state     <= IDLE;
            frame_err <= !rxd_sync;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  // Sticky overrun: set when a good byte finds no room; set beats clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun <= 1'b0;
    end else if (fifo_drop) begin
      overrun <= 1'b1;
    end else if (overrun_clr) begin
      overrun <= 1'b0;
    end
  end

  uart_rx_fifo u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (shreg),
    .pop       (pop),
    .head      (rx_data),
    .valid     (rx_valid),
    .drop      (fifo_drop)
  );

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial 8N1 UART receiver with a 4-entry byte FIFO. It is the receiving end of the system's `uart_txd` line, and acts as the comm partner that captures bytes sent by the LM32 `system`. It lets benches and FPGA top levels consume the system's UART output as ready/valid bytes. It decodes with mid-bit sampling at `clk_freq/uart_baud_rate` clocks per bit and reports framing and overrun errors.

## Interface
- `clk_freq`, default 100000000: clock frequency in Hz.
- `uart_baud_rate`, default 1152000: line rate in baud. `DIV = clk_freq/uart_baud_rate` (truncated) is the clocks per bit, and must be at least 8. The defaults give `DIV = 86`.
- `clk` in 1: single clock, all logic on the rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `uart_rxd` in 1: serial line, idle high, asynchronous to `clk`.
- `rx_data` out 8: FIFO head byte. Valid only while `rx_valid` is high.
- `rx_valid` out 1: FIFO not empty.
- `rx_ready` in 1: consumer accepts the head byte when `rx_valid && rx_ready`.
- `frame_err` out 1: one-cycle pulse when a stop bit is sampled low.
- `overrun` out 1: sticky. Set when a good byte completes while the FIFO is full.
- `overrun_clr` in 1: synchronous clear of `overrun`.
- `busy` out 1: high whenever the receiver FSM is not in IDLE.

## Operation
- `uart_rxd` passes through a 2-flop synchronizer; the sync flops reset to 1. A third flop holds the previous synchronized value for falling-edge detection.
- FSM states, with a bit-timer `cnt` (up to DIV-1) and a bit index `idx` (0..7):
  - IDLE: on a synchronized 1→0 edge, go to START with `cnt` loaded to `DIV/2 - 1`.
  - START: when `cnt` reaches 0, sample the line.
    - Sample low: go to DATA with `cnt = DIV-1` and `idx = 0`.
    - Sample high: false start, return to IDLE with no output.
  - DATA: when `cnt` reaches 0, shift the sample into the shift register LSB-first and reload `cnt = DIV-1`. After `idx == 7`, go to STOP.
  - STOP: when `cnt` reaches 0, sample the stop bit.
    - Sample high: push the byte into the FIFO, or drop it and set `overrun` if the FIFO is full.
    - Sample low: pulse `frame_err` and drop the byte.
    - In both cases, return to IDLE in the same cycle.
- A new start edge is accepted from the first IDLE cycle. No extra idle time is required after the mid-stop sample.
- FIFO: depth 4, 8 bits wide, with 2-bit pointers and a 3-bit count.
  - A push and a pop in the same cycle on a full FIFO are both allowed: the count is unchanged and no overrun occurs, because the pop frees the slot first.
  - A pop when empty is ignored.
- `overrun_clr` and an overrun set in the same cycle: set wins.

## Timing
- Reset values:
  - `rx_valid=0`, `frame_err=0`, `overrun=0`, `busy=0`.
  - `rx_data=8'h00`; the FIFO storage resets to 0.
  - FSM in IDLE, all pointers and counters 0.
- Reset asserted mid-frame aborts the frame: no push, no `frame_err`. After release, the receiver waits for a fresh falling edge.
- Edge-detect latency is 3 clocks from a `uart_rxd` fall to `busy` going high.
- Each sample point lies `DIV/2 + k*DIV` clocks after edge detection, for k = 0 (start) through 9 (stop).
- A byte appears on `rx_valid`/`rx_data` 1 clock after the stop-bit sample, which is registered FIFO status.
- `frame_err` is high for exactly the 1 clock following the stop-bit sample.
- `rx_data` changes only on a pop, or on a push into an empty FIFO. It is stable while `rx_valid && !rx_ready`.

## Structure
- Package `uart_pkg`:
  - FSM state enum: IDLE, START, DATA, STOP.
  - The `DIV` computation as a function of `clk_freq` and `uart_baud_rate`.
  - FIFO depth constant `RX_FIFO_DEPTH = 4`.
- One sub-module `uart_rx_fifo`: synchronous 4x8 FIFO with push/pop, full/empty and registered outputs. The FSM, synchronizer and error flags stay in `uart_rx`.

## Test plan
All scenarios use `tck = 10 ns`, the default parameters, and bit period 860 ns.
- Single byte: drive 8'hA5 (8N1, LSB-first) with `rx_ready=1` → one `rx_valid` cycle with `rx_data=8'hA5`, `frame_err=0`, `busy=0` afterwards.
- False start: a 200 ns low glitch on an idle line → `busy` pulses, then returns low with no `rx_valid` and no `frame_err`.
- Framing error: send 8'h3C with the stop bit held low → `frame_err` pulses for 1 clock and the FIFO stays empty.
- Fill and overrun: `rx_ready=0`, send 8'h01 through 8'h05 back-to-back → `overrun=1` after the 5th byte. Then `rx_ready=1` drains 8'h01 through 8'h04 in order. `overrun_clr` then clears `overrun`.
- Concurrent push/pop: FIFO full, pop exactly on the 5th byte's push cycle → no overrun; the drained order ends with the 5th byte.
- Reset mid-frame: assert `rst` during data bit 3 of 8'hFF, then send 8'h5A → only 8'h5A is received.
